func_param: RTL and testbench
=============================

# func_param

Parametrised successor of the fixed 8-bit cube-plus-root unit. It computes y = a^p + floor(sqrt(b)) for W-bit unsigned operands, with p = 3 or p = 2 selected per operation, using one internal sequential shift-add multiplier and a concurrent digit-by-digit square-root engine. It sits on the same start/busy handshake as its predecessor and adds an explicit one-cycle valid_o pulse, so zero results are reported correctly.

## Interface
- W, 8: operand width; must be even, 4..16.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only while idle.
- mode_i  in  1  0: y = a^3 + isqrt(b); 1: y = a^2 + isqrt(b); captured at accept.
- a_i  in  W  unsigned operand a; captured at accept.
- b_i  in  W  unsigned operand b; captured at accept.
- busy_o  out  1  high while an operation is in flight.
- valid_o  out  1  one-cycle pulse; y_o is new in that cycle.
- y_o  out  3W  result; holds its value until the next result or reset.

## Operation
- States: IDLE, MUL1, MUL2, ADD. busy_o = (state != IDLE).
- IDLE: if start_i, register a, b, mode; clear the multiplier accumulator, bit counter, root/remainder registers; go to MUL1.
- MUL1: computes a*a, LSB-first shift-add, one multiplier bit per cycle, W cycles. At the end, if mode=0, the 2W-bit product becomes the multiplicand and the state goes to MUL2; if mode=1, the state goes to ADD.
- MUL2: computes (a*a)*a, W cycles, 3W-bit product; then goes to ADD.
- Sqrt engine: starts at accept, runs in parallel, W/2 iterations (one per cycle) of restoring digit-by-digit root over bit pairs of b, MSB pair first. It produces a W/2-bit floor root and then holds it. It always finishes before ADD (W/2 <= W).
- ADD: y_o <= power (zero-extended to 3W) + root (zero-extended); valid_o <= 1; go to IDLE.
- No overflow is possible: (2^W-1)^3 + 2^(W/2)-1 < 2^(3W).
- start_i while busy: ignored. No queueing and no effect on the current operation.
- Input changes after accept: ignored.
- Completion does not depend on result value; a=0, b=0 completes normally with y_o=0.

## Timing
- Reset (rst_i high at an edge): state=IDLE, busy_o=0, valid_o=0, y_o=0, internal registers cleared. This applies at any point, including mid-operation; the in-flight operation is aborted and no valid_o is produced.
- Accept edge k (IDLE, start_i=1): busy_o=1 from edge k.
- mode=0: MUL1 covers edges k+1..k+W; MUL2 covers k+W+1..k+2W; ADD result at edge k+2W+1. Latency is 2W+1 cycles.
- mode=1: ADD result at edge k+W+1. Latency is W+1 cycles.
- At the result edge: y_o updates, valid_o=1 for exactly one cycle, busy_o=0.
- start_i high during the valid_o cycle is accepted on the next edge. Back-to-back period is 2W+2 cycles for mode=0 and W+2 cycles for mode=1.
- valid_o is 0 in every cycle other than the result cycle.

## Test plan
- W=8, mode=0, a=255, b=255 -> y_o=16581390 (16581375+15); valid_o one cycle, 17 cycles after accept; busy_o high 17 cycles.
- W=8, mode=0, a=0, b=0 -> y_o=0 with valid_o pulse at +17; then a=2, b=9 -> y_o=11.
- W=8, mode=1, a=200, b=100 -> y_o=40010 at +9 cycles. Keep start_i high through valid_o -> second operation accepted on the next edge.
- W=8: start_i pulses and a_i/b_i changes during MUL1/MUL2 -> ignored; result and timing unchanged from the original operands (a=3, b=16 -> 31).
- W=8: rst_i asserted for one edge at +5 of an operation -> busy_o=0, y_o=0, no valid_o. A new operation afterwards completes correctly.
- W=4 instance, mode=0, a=15, b=15 -> y_o=3378 (3375+3) at +9 cycles; y_o width 12 bits.

Source files
------------

// File: rtl/func_param.sv
// Computes y = a^3 + isqrt(b) (mode 0) or y = a^2 + isqrt(b) (mode 1) for W-bit operands,
// using one sequential shift-add multiplier and a digit-by-digit square root running alongside it.
module func_param #(
  parameter int W = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           mode_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           valid_o,
  output logic [3*W-1:0] y_o
);

  localparam int H  = W / 2;
  localparam int RW = H + 3;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    ADD
  } state_t;

  state_t state, state_next;

  logic [W-1:0]   a_q;
  logic           mode_q;
  logic [3*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [3*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   bsh;
  logic [RW-1:0]  rem;
  logic [H-1:0]   root;
  logic [CW-1:0]  scnt;

  logic [3*W-1:0] step_sum;
  logic           mul_last;
  logic [RW-1:0]  rem_t;
  logic [RW-1:0]  trial;
  logic           fits;
  logic           sqrt_run;

  // Datapath helpers: one shift-add step and one root digit per cycle.
  always_comb begin
    step_sum = acc + (mplier[0] ? mcand : '0);
    mul_last = (cnt == CW'(W - 1));
    rem_t    = (rem << 2) | RW'(bsh[W-1:W-2]);
    trial    = {1'b0, root, 2'b01};
    fits     = (rem_t >= trial);
    sqrt_run = (scnt < CW'(H));
  end

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = MUL1;
      MUL1: if (mul_last) state_next = mode_q ? ADD : MUL2;
      MUL2: if (mul_last) state_next = ADD;
      ADD:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      valid_o <= 1'b0;
      y_o     <= '0;
      a_q     <= '0;
      mode_q  <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      bsh     <= '0;
      rem     <= '0;
      root    <= '0;
      scnt    <= '0;
    end else begin
      state   <= state_next;
      valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            a_q    <= a_i;
            mode_q <= mode_i;
            mcand  <= {{(2*W){1'b0}}, a_i};
            mplier <= a_i;
            acc    <= '0;
            cnt    <= '0;
            bsh    <= b_i;
            rem    <= '0;
            root   <= '0;
            scnt   <= '0;
          end
        end
        MUL1, MUL2: begin
          if (mul_last && state == MUL1 && !mode_q) begin
            // a*a becomes the multiplicand for the second pass against a.
            mcand  <= step_sum;
            mplier <= a_q;
            acc    <= '0;
            cnt    <= '0;
          end else begin
            acc    <= step_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        ADD: begin
          y_o     <= acc + {{(3*W-H){1'b0}}, root};
          valid_o <= 1'b1;
        end
        default: ;
      endcase

      // Root engine runs from accept for H cycles, then holds its result until ADD.
      if (state != IDLE && sqrt_run) begin
        rem  <= fits ? (rem_t - trial) : rem_t;
        root <= {root[H-2:0], fits};
        bsh  <= {bsh[W-3:0], 2'b00};
        scnt <= scnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_func_param.sv
// Randomised self-checking bench for func_param: W=8 and W=4 instances against an arithmetic model.
module tb_func_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic [7:0]  a     = '0;
  logic [7:0]  b     = '0;
  logic        busy;
  logic        valid;
  logic [23:0] y;

  logic        start4 = 1'b0;
  logic        mode4  = 1'b0;
  logic [3:0]  a4     = '0;
  logic [3:0]  b4     = '0;
  logic        busy4;
  logic        valid4;
  logic [11:0] y4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  func_param #(.W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .a_i(a), .b_i(b), .busy_o(busy), .valid_o(valid), .y_o(y)
  );

  func_param #(.W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .mode_i(mode4),
    .a_i(a4), .b_i(b4), .busy_o(busy4), .valid_o(valid4), .y_o(y4)
  );

  function automatic longint ref_y(input int m, input longint av, input longint bv);
    longint pw, r;
    pw = (m != 0) ? av * av : av * av * av;
    r = 0;
    while ((r + 1) * (r + 1) <= bv) r++;
    return pw + r;
  endfunction

  // Runs one W=8 operation from a negedge; returns result, latency in edges, busy cycles, valid after.
  task automatic op8(input logic m, input logic [7:0] av, input logic [7:0] bv, input bit noise,
                     output logic [23:0] yv, output int lat, output int busy_cnt, output logic v_after);
    mode = m; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    yv = 'x;
    while (lat < 60) begin
      if (noise) begin
        a = 8'($urandom);
        b = 8'($urandom);
        mode = 1'($urandom);
        start = (lat < 6) ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
      lat++;
      if (valid) begin
        yv = y;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    @(negedge clk);
    v_after = valid;
  endtask

  task automatic op4(input logic m, input logic [3:0] av, input logic [3:0] bv,
                     output logic [11:0] yv, output int lat);
    mode4 = m; a4 = av; b4 = bv; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    yv = 'x;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (valid4) begin
        yv = y4;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (y !== 24'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
    checks++; if (y4 !== 12'd0 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_w4 got y=%0d busy=%b want 0/0", y4, busy4); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [23:0] yv; int lat, bc; logic va;
    logic        m_t[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  a_t[4] = '{8'd255, 8'd0, 8'd2, 8'd200};
    logic [7:0]  b_t[4] = '{8'd255, 8'd0, 8'd9, 8'd100};
    longint      e_t[4] = '{16581390, 0, 11, 40010};
    for (int i = 0; i < 4; i++) begin
      op8(m_t[i], a_t[i], b_t[i], 1'b0, yv, lat, bc, va);
      checks++; if (yv !== e_t[i][23:0]) begin errors++; $display("FAIL directed_y[%0d] got %0d want %0d", i, yv, e_t[i]); end
      checks++; if (lat != (m_t[i] ? 9 : 17)) begin errors++; $display("FAIL directed_lat[%0d] got %0d want %0d", i, lat, m_t[i] ? 9 : 17); end
      checks++; if (bc != (m_t[i] ? 9 : 17)) begin errors++; $display("FAIL directed_busy[%0d] got %0d want %0d", i, bc, m_t[i] ? 9 : 17); end
      checks++; if (va !== 1'b0) begin errors++; $display("FAIL directed_pulse[%0d] valid still %b want 0", i, va); end
      checks++; if (y !== e_t[i][23:0]) begin errors++; $display("FAIL directed_hold[%0d] got %0d want %0d", i, y, e_t[i]); end
    end
  endtask

  task automatic test_ignore_inputs();
    logic [23:0] yv; int lat, bc; logic va;
    op8(1'b0, 8'd3, 8'd16, 1'b1, yv, lat, bc, va);
    checks++; if (yv !== 24'd31) begin errors++; $display("FAIL ignore_y got %0d want 31", yv); end
    checks++; if (lat != 17) begin errors++; $display("FAIL ignore_lat got %0d want 17", lat); end
    checks++; if (bc != 17) begin errors++; $display("FAIL ignore_busy got %0d want 17", bc); end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    mode = 1'b1; a = 8'd200; b = 8'd100; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (lat < 40 && !valid) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 9 || y !== 24'd40010) begin errors++; $display("FAIL b2b_first got lat=%0d y=%0d want 9/40010", lat, y); end
    mode = 1'b1; a = 8'd7; b = 8'd50;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", busy); end
    lat2 = 1;
    while (lat2 < 40 && !valid) begin
      @(negedge clk);
      lat2++;
    end
    checks++; if (lat2 != 10 || y !== 24'd56) begin errors++; $display("FAIL b2b_second got period=%0d y=%0d want 10/56", lat2, y); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [23:0] yv; int lat, bc; logic va;
    logic m; logic [7:0] av, bv; longint e;
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom); av = 8'($urandom); bv = 8'($urandom);
      if (i == 0) av = 8'd255;
      if (i == 1) bv = 8'd0;
      e = ref_y(int'(m), longint'(av), longint'(bv));
      op8(m, av, bv, 1'b1, yv, lat, bc, va);
      checks++; if (yv !== e[23:0] || lat != (m ? 9 : 17))
        begin errors++; $display("FAIL random[%0d] m=%0d a=%0d b=%0d got y=%0d lat=%0d want y=%0d lat=%0d", i, m, av, bv, yv, lat, e, m ? 9 : 17); end
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] yv; int lat, bc; logic va; int vcount;
    mode = 1'b0; a = 8'd9; b = 8'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || y !== 24'd0 || valid !== 1'b0)
      begin errors++; $display("FAIL midreset got busy=%b y=%0d valid=%b want 0/0/0", busy, y, valid); end
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL midreset_novalid got %0d pulses want 0", vcount); end
    op8(1'b0, 8'd5, 8'd200, 1'b0, yv, lat, bc, va);
    checks++; if (yv !== 24'd139 || lat != 17) begin errors++; $display("FAIL midreset_after got y=%0d lat=%0d want 139/17", yv, lat); end
  endtask

  task automatic test_w4();
    logic [11:0] yv; int lat; logic m; logic [3:0] av, bv; longint e;
    op4(1'b0, 4'd15, 4'd15, yv, lat);
    checks++; if (yv !== 12'd3378 || lat != 9) begin errors++; $display("FAIL w4_max got y=%0d lat=%0d want 3378/9", yv, lat); end
    for (int i = 0; i < 10; i++) begin
      m = 1'($urandom); av = 4'($urandom); bv = 4'($urandom);
      e = ref_y(int'(m), longint'(av), longint'(bv));
      op4(m, av, bv, yv, lat);
      checks++; if (yv !== e[11:0] || lat != (m ? 5 : 9))
        begin errors++; $display("FAIL w4_random[%0d] got y=%0d lat=%0d want y=%0d lat=%0d", i, yv, lat, e, m ? 5 : 9); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_inputs();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_w4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
